// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, redirect, decode handshake.
// The master side is the fetch unit; the slave side is the pipeline around it.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, id_pc_plus4,
        input  id_ready,
        output misalign_err
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, id_pc_plus4,
        output id_ready,
        input  misalign_err
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, imem requests, tagged response queue, redirect flush.
// Define FETCH_ALIGN_CHECK_EN to flag misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic        clk,
    input logic        rst_n,
    fetch_unit_if.master bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    logic [31:0]           fetch_pc;
    logic [31:0]           q_pc    [FIFO_DEPTH];
    logic [31:0]           q_instr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] q_filled;
    logic [AW-1:0]         head, tail, fptr;
    logic [AW:0]           occ, unf;
    // Repeated redirects against a slow memory can stack discards, so
    // this counter is kept wider than the queue.
    logic [7:0]            drop_cnt;
    logic                  run;
    logic                  hv, req_fire, rsp_take, rsp_drop, pop;

    assign hv       = (occ != '0) && q_filled[head];
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_drop = bus.imem_rsp_valid && (drop_cnt != '0);
    assign rsp_take = bus.imem_rsp_valid && (drop_cnt == '0)
                    && (unf != '0);
    assign pop      = hv && bus.id_ready;

    assign bus.imem_req_valid = run && (occ < DEPTH)
                              && !bus.redirect_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.id_valid       = hv;
    assign bus.id_instr       = hv ? q_instr[head] : '0;
    assign bus.id_pc          = hv ? q_pc[head] : '0;
    assign bus.id_pc_plus4    = hv ? q_pc[head] + 32'd4 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            fptr     <= '0;
            occ      <= '0;
            unf      <= '0;
            drop_cnt <= '0;
            q_filled <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                head     <= '0;
                tail     <= '0;
                fptr     <= '0;
                occ      <= '0;
                unf      <= '0;
                q_filled <= '0;
                drop_cnt <= drop_cnt + 8'(unf)
                          - 8'(rsp_drop) - 8'(rsp_take);
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    q_pc[i]    <= '0;
                    q_instr[i] <= '0;
                end
            end else begin
                if (rsp_drop)
                    drop_cnt <= drop_cnt - 8'd1;
                if (rsp_take) begin
                    q_instr[fptr]  <= bus.imem_rsp_data;
                    q_filled[fptr] <= 1'b1;
                    fptr           <= fptr + 1'b1;
                end
                if (req_fire) begin
                    q_pc[tail]     <= fetch_pc;
                    q_filled[tail] <= 1'b0;
                    tail           <= tail + 1'b1;
                    fetch_pc       <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    q_filled[head] <= 1'b0;
                    head           <= head + 1'b1;
                end
                occ <= occ + (AW+1)'(req_fire) - (AW+1)'(pop);
                unf <= unf + (AW+1)'(req_fire) - (AW+1)'(rsp_take);
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mis <= 1'b0;
        else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00))
            mis <= 1'b1;
    end

    assign bus.misalign_err = mis;
`else
    assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: sequential-PC delivery model, latency-L memory,
// per-cycle compare process plus directed literal checks.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic ALIGN = 1'b1;
`else
    localparam logic ALIGN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pend[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Memory: in-order, responds lat cycles after the request cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    end

    logic [31:0] exp_pc, exp_req, h_pc, h_instr;
    logic        exp_mis, hold, redir_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc     = 32'h0;
            exp_req    = 32'h0;
            exp_mis    = 1'b0;
            hold       = 1'b0;
            redir_prev = 1'b0;
        end else begin
            chk("misalign", 32'(bus.misalign_err), 32'(exp_mis));
            if (!bus.id_valid) begin
                chk("zero_instr", bus.id_instr, 32'h0);
                chk("zero_pc", bus.id_pc, 32'h0);
                chk("zero_pc4", bus.id_pc_plus4, 32'h0);
            end
            if (redir_prev)
                chk("idv_after_redir", 32'(bus.id_valid), 32'h0);
            if (hold) begin
                chk("hold_valid", 32'(bus.id_valid), 32'h1);
                chk("hold_pc", bus.id_pc, h_pc);
                chk("hold_instr", bus.id_instr, h_instr);
            end
            if (bus.redirect_valid) begin
                chk("req_in_redir", 32'(bus.imem_req_valid), 32'h0);
                exp_pc  = bus.redirect_pc & ~32'h3;
                exp_req = exp_pc;
                if (ALIGN && bus.redirect_pc[1:0] != 2'b00)
                    exp_mis = 1'b1;
                redir_prev = 1'b1;
                hold       = 1'b0;
            end else begin
                redir_prev = 1'b0;
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    chk("req_addr", bus.imem_req_addr, exp_req);
                    pend.push_back('{bus.imem_req_addr, cyc + lat});
                    exp_req = exp_req + 32'd4;
                end
                if (bus.id_valid && bus.id_ready) begin
                    chk("id_pc", bus.id_pc, exp_pc);
                    chk("id_instr", bus.id_instr, mem(exp_pc));
                    chk("id_pc4", bus.id_pc_plus4, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                end
                hold    = bus.id_valid && !bus.id_ready;
                h_pc    = bus.id_pc;
                h_instr = bus.id_instr;
            end
        end
    end

    task automatic redirect(input logic [31:0] t);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = t;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic expect_next(input string nm, input logic [31:0] want,
                               output logic [31:0] pc4);
        bit got = 1'b0;
        pc4 = 'x;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
                got = 1'b1;
                pc4 = bus.id_pc_plus4;
                chk(nm, bus.id_pc, want);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no delivery, expected pc %h", nm, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] p4;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'h0);
        chk("rst_id_instr", bus.id_instr, 32'h0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
        chk("rst_id_pc4", bus.id_pc_plus4, 32'h0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'h0);
        #2 rst_n = 1'b1;

        @(negedge clk);
        chk("c0_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("c0_req_addr", bus.imem_req_addr, 32'h0);
        chk("c0_id_valid", 32'(bus.id_valid), 32'h0);
        @(negedge clk);
        chk("c1_req_addr", bus.imem_req_addr, 32'h4);
        chk("c1_id_valid", 32'(bus.id_valid), 32'h0);
        @(negedge clk);
        chk("c2_id_valid", 32'(bus.id_valid), 32'h1);
        chk("c2_id_pc", bus.id_pc, 32'h0);
        chk("c2_id_instr", bus.id_instr, 32'h0000_0013);
        chk("c2_id_pc4", bus.id_pc_plus4, 32'h4);
        repeat (6) @(negedge clk);

        // Decode stall for five cycles.
        @(posedge clk);
        #1 bus.id_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_req_low", 32'(bus.imem_req_valid), 32'h0);
        chk("stall_id_valid", 32'(bus.id_valid), 32'h1);
        @(negedge clk);
        @(posedge clk);
        #1 bus.id_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Mixed backpressure on both sides.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            bus.imem_req_ready = (i % 2) == 0;
            bus.id_ready       = (i % 3) != 0;
        end
        @(posedge clk);
        #1;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b1;
        repeat (4) @(negedge clk);

        // Slow memory, redirect with fetches in flight.
        lat = 3;
        repeat (8) @(negedge clk);
        redirect(32'h0000_0100);
        expect_next("lat3_redir_pc", 32'h0000_0100, p4);
        repeat (6) @(negedge clk);
        lat = 1;
        repeat (6) @(negedge clk);

        // Redirects landing on different response/handshake phases.
        for (int ph = 0; ph < 3; ph++) begin
            repeat (ph + 4) @(negedge clk);
            redirect(32'h0000_0200 + 32'(ph) * 32'h40);
            expect_next("phase_redir_pc",
                        32'h0000_0200 + 32'(ph) * 32'h40, p4);
        end

        // Address wrap at 2^32.
        redirect(32'hFFFF_FFF8);
        expect_next("wrap_pc0", 32'hFFFF_FFF8, p4);
        expect_next("wrap_pc1", 32'hFFFF_FFFC, p4);
        chk("wrap_pc4", p4, 32'h0000_0000);
        expect_next("wrap_pc2", 32'h0000_0000, p4);

        // Misaligned target.
        redirect(32'h0000_0102);
        expect_next("mis_pc", 32'h0000_0100, p4);
        chk("mis_flag", 32'(bus.misalign_err), 32'(ALIGN));
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-operation.
        @(posedge clk);
        #3 rst_n = 1'b0;
        pend.delete();
        #1;
        chk("arst_id_valid", 32'(bus.id_valid), 32'h0);
        chk("arst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("arst_id_pc", bus.id_pc, 32'h0);
        chk("arst_misalign", 32'(bus.misalign_err), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        expect_next("post_rst_pc", 32'h0000_0000, p4);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
